// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in/parallel-out word assembler with held output and valid/ready flow control
module sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    bit_count
);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic             accept;
    logic             last;
    assign last     = bit_count == LAST;
    assign in_ready = !clear && !(out_valid && last);
    assign accept   = serial_valid && in_ready;
    // next partial word with the incoming bit merged at the configured end
    always_comb sh_next = MSB_FIRST ? {sh[WIDTH-2:0], serial_in} : {serial_in, sh[WIDTH-1:1]};
    // shift/count, publish a completed word, and retire it on consume
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh           <= '0;
            bit_count    <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (clear) begin
                sh        <= '0;
                bit_count <= '0;
            end else if (accept && last) begin
                parallel_out <= sh_next;
                out_valid    <= 1'b1;
                sh           <= '0;
                bit_count    <= '0;
            end else if (accept) begin
                sh        <= sh_next;
                bit_count <= bit_count + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: MSB- and LSB-first instances against a bit-queue reference model
module tb_sipo_deserializer;
    localparam int W = 8;
    localparam int C = $clog2(W);
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic serial_in = 1'b0;
    logic serial_valid = 1'b0;
    logic clear = 1'b0;
    logic out_ready = 1'b0;
    logic [W-1:0] po_m, po_l;
    logic ov_m, ov_l, ir_m, ir_l;
    logic [C-1:0] bc_m, bc_l;
    int n_checks = 0;
    int n_fail = 0;
    bit q[$];
    int m_msb = 0;
    int m_lsb = 0;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
        .in_ready(ir_m), .clear(clear), .parallel_out(po_m), .out_valid(ov_m),
        .out_ready(out_ready), .bit_count(bc_m)
    );
    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
        .in_ready(ir_l), .clear(clear), .parallel_out(po_l), .out_valid(ov_l),
        .out_ready(out_ready), .bit_count(bc_l)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: the partial word is a queue of received bits; words are built by weighting
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            q.delete();
            m_msb = 0;
            m_lsb = 0;
            m_valid = 1'b0;
        end else begin
            bit rdy;
            rdy = !clear && !(m_valid && q.size() == W - 1);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (clear) q.delete();
            else if (serial_valid && rdy) begin
                q.push_back(serial_in);
                if (q.size() == W) begin
                    m_msb = 0;
                    m_lsb = 0;
                    for (int i = 0; i < W; i++) begin
                        m_msb += int'(q[i]) * (1 << (W - 1 - i));
                        m_lsb += int'(q[i]) * (1 << i);
                    end
                    m_valid = 1'b1;
                    q.delete();
                end
            end
            #1;
            if (!reset) begin
                chk("po_msb", int'(po_m), m_msb);
                chk("po_lsb", int'(po_l), m_lsb);
                chk("valid_msb", int'(ov_m), int'(m_valid));
                chk("valid_lsb", int'(ov_l), int'(m_valid));
                chk("count_msb", int'(bc_m), q.size());
                chk("count_lsb", int'(bc_l), q.size());
                chk("ready_msb", int'(ir_m), int'(!clear && !(m_valid && q.size() == W - 1)));
                chk("ready_lsb", int'(ir_l), int'(!clear && !(m_valid && q.size() == W - 1)));
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial_valid = 1'b1;
        serial_in = b;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
        @(negedge clk);
        serial_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_po"}, int'(po_m), 0);
        chk({tag, "_po_l"}, int'(po_l), 0);
        chk({tag, "_valid"}, int'(ov_m), 0);
        chk({tag, "_count"}, int'(bc_m), 0);
        chk({tag, "_ready"}, int'(ir_m), 1);
    endtask

    initial begin
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        send_word(8'hB2);
        chk("msb_word", int'(po_m), 'hB2);
        chk("lsb_word", int'(po_l), 'h4D);
        chk("word_valid", int'(ov_m), 1);
        chk("word_count", int'(bc_m), 0);
        @(negedge clk);
        chk("consumed", int'(ov_m), 0);
        chk("held_after_consume", int'(po_m), 'hB2);
        out_ready = 1'b0;
        send_word(8'hB2);
        for (int i = 0; i < W - 1; i++) send_bit(1'b1);
        @(negedge clk);
        chk("stall_count", int'(bc_m), W - 1);
        chk("stall_ready", int'(ir_m), 0);
        chk("stall_po", int'(po_m), 'hB2);
        repeat (2) @(negedge clk);
        chk("stall_hold", int'(bc_m), W - 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("unstall_valid", int'(ov_m), 0);
        chk("unstall_ready", int'(ir_m), 1);
        @(negedge clk);
        serial_valid = 1'b0;
        chk("ones_word", int'(po_m), 'hFF);
        chk("ones_valid", int'(ov_m), 1);
        repeat (5) send_bit(1'b1);
        @(negedge clk);
        clear = 1'b1;
        serial_in = 1'b1;
        #1;
        chk("clear_ready", int'(ir_m), 0);
        chk("clear_pre_count", int'(bc_m), 5);
        @(negedge clk);
        clear = 1'b0;
        serial_valid = 1'b0;
        chk("clear_count", int'(bc_m), 0);
        chk("clear_po", int'(po_m), 'hFF);
        chk("clear_valid", int'(ov_m), 1);
        out_ready = 1'b1;
        send_word(8'h3A);
        out_ready = 1'b0;
        chk("clean_msb", int'(po_m), 'h3A);
        chk("clean_lsb", int'(po_l), 'h5C);
        chk("clean_valid", int'(ov_m), 1);
        repeat (3) send_bit(1'b1);
        @(negedge clk);
        serial_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        send_word(8'h0F);
        chk("post_reset_msb", int'(po_m), 'h0F);
        chk("post_reset_lsb", int'(po_l), 'hF0);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 599) == 0) reset = 1'b1;
            serial_valid = $urandom_range(0, 3) != 0;
            serial_in = 1'($urandom);
            out_ready = i % 1000 < 300 ? 1'b1 : 1'($urandom);
            clear = $urandom_range(0, 39) == 0;
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Parametrised serial-in/parallel-out deserializer with framing and handshakes. Shifts in one bit per accepted beat, counts bits, and presents each completed WIDTH-bit word on a held output register with valid/ready flow control. Bit order is selectable at elaboration time. It sits between a bit-serial receive front end, such as a serial link or sampled pin, and word-oriented logic, replacing the free-running shift register wherever word boundaries and backpressure matter.

## Interface
- `WIDTH`, 8, word width in bits; legal range ≥ 2.
- `MSB_FIRST`, 1, bit order. 1: the first received bit lands in bit WIDTH-1. 0: the first received bit lands in bit 0.
- `CW`, $clog2(WIDTH), width of the bit counter. This is derived and must not be overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `serial_in`  in  1  serial data bit.
- `serial_valid`  in  1  `serial_in` is valid this cycle.
- `in_ready`  out  1  the block accepts a bit this cycle.
- `clear`  in  1  synchronous abort of the partial word.
- `parallel_out`  out  WIDTH  last completed word, held stable.
- `out_valid`  out  1  `parallel_out` holds an unconsumed word.
- `out_ready`  in  1  the consumer takes the word this cycle.
- `bit_count`  out  CW  number of bits currently in the partial word (0..WIDTH-1).

## Operation
- **State.**
  - Shift register `sh[WIDTH-1:0]`.
  - Counter `bit_count`.
  - Output register `parallel_out`.
  - Flag `out_valid`.
- **Accept.** A bit is accepted when `serial_valid && in_ready`.
- **in_ready.** `in_ready = !clear && !(out_valid && bit_count == WIDTH-1)`. The only combinational input dependency is `clear`; `out_ready` is not used.
- **Shift on accept, MSB_FIRST=1.** `sh <= {sh[WIDTH-2:0], serial_in}`.
- **Shift on accept, MSB_FIRST=0.** `sh <= {serial_in, sh[WIDTH-1:1]}`.
- **Counting.** On accept with `bit_count < WIDTH-1`, the shift is applied and `bit_count` increments.
- **Word complete.** On accept with `bit_count == WIDTH-1`:
  - `parallel_out` loads the shifted word, including this bit.
  - `out_valid` is set to 1.
  - `bit_count` returns to 0.
  - `sh` is cleared to 0.
- **Consume.** When `out_valid && out_ready`, `out_valid` is set to 0.
  - `parallel_out` keeps its value after consumption.
  - A load and a consume cannot coincide, because `in_ready` blocks the final bit while `out_valid` is 1.
- **Double buffering.** While a word is held, the next word accumulates in `sh` up to WIDTH-1 bits. The final bit then stalls until the held word is consumed.
- **Clear.** `clear` has priority over accept:
  - `sh` and `bit_count` go to 0.
  - A bit presented in the same cycle is not accepted, because `in_ready` is 0.
  - `parallel_out` and `out_valid` are unaffected.
- **No valid.** With `serial_valid` = 0, the state holds, apart from consumption.

## Timing
- **Reset values** (asynchronous, immediate):
  - `parallel_out` = 0
  - `out_valid` = 0
  - `bit_count` = 0
  - `sh` = 0
  - `in_ready` = 1, provided `clear` = 0
- **Reset mid-word or mid-handshake.** The partial word and the held word are both discarded. After reset deasserts, the first accepted bit is bit 0 of a new word.
- **Latency.** `out_valid` and the new `parallel_out` appear on the edge that accepts the WIDTH-th bit, and are visible the cycle after.
- **Throughput.** With `out_ready` held high and `serial_valid` continuous: one word every WIDTH cycles, with no stall.
- **Stall boundary.** If `out_valid` = 1 when `bit_count` reaches WIDTH-1:
  - `in_ready` drops in that cycle.
  - It returns to 1 in the cycle after the consume edge.
- **Counter wrap.** `bit_count` wraps from WIDTH-1 to 0 only on word completion. It never reaches WIDTH.

## Test plan
- **Reset.** Assert `reset` → `parallel_out` = 0, `out_valid` = 0, `bit_count` = 0, `in_ready` = 1.
- **MSB-first word.** WIDTH=8, MSB_FIRST=1, `out_ready`=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles → `parallel_out` = 8'hB2 and `out_valid` high for one cycle, the cycle after the 8th bit; `bit_count` back to 0.
- **LSB-first word.** MSB_FIRST=0, same bit sequence → `parallel_out` = 8'h4D.
- **Backpressure.** `out_ready`=0 after word 8'hB2, then 8 bits of 1:
  - After 7 bits: `bit_count` = 7, `in_ready` = 0, `parallel_out` still 8'hB2.
  - Pulse `out_ready` → `in_ready` = 1 next cycle; the 8th bit yields 8'hFF.
- **Clear.** `clear` after 5 bits → `bit_count` = 0 and the held word is unchanged. A bit presented with `clear` high is not counted. The next 8 bits form a clean word.
- **Reset mid-word.** Assert `reset` after 3 bits with `out_valid` = 1 → all state is 0. Then bits 0,0,0,0,1,1,1,1 (MSB_FIRST=1) → 8'h0F.
